// File: rtl/apb_req_master28_pkg.sv
// Shared types and helpers for the APB request master.
package apb_req_master28_pkg;

  // Transfer phase of the APB initiator.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } state_e;

  localparam int unsigned ADDR_W_DEF = 7;
  localparam int unsigned DATA_W_DEF = 32;

  // Packed request record is {write, addr, wdata}.
  function automatic int unsigned req_width(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw;
  endfunction

  localparam int unsigned REQ_W_DEF = 1 + ADDR_W_DEF + DATA_W_DEF;

endpackage

// File: rtl/apb_req_master28_if.sv
// Request/response port plus APB bus of the request master, bundled with modports.
interface apb_req_master28_if
  import apb_req_master28_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
  parameter int unsigned DATA_WIDTH = DATA_W_DEF
);
  logic                  req_valid28;
  logic                  req_ready28;
  logic                  req_write28;
  logic [ADDR_WIDTH-1:0] req_addr28;
  logic [DATA_WIDTH-1:0] req_wdata28;
  logic                  rsp_valid28;
  logic                  rsp_write28;
  logic [DATA_WIDTH-1:0] rsp_rdata28;
  logic                  rsp_timeout28;
  logic                  psel28;
  logic                  penable28;
  logic                  pwrite28;
  logic [ADDR_WIDTH-1:0] paddr28;
  logic [DATA_WIDTH-1:0] pwdata28;
  logic [DATA_WIDTH-1:0] prdata28;
  logic                  pready28;

  // Initiator side (the master block itself).
  modport master (
    input  req_valid28, req_write28, req_addr28, req_wdata28, prdata28, pready28,
    output req_ready28, rsp_valid28, rsp_write28, rsp_rdata28, rsp_timeout28,
    output psel28, penable28, pwrite28, paddr28, pwdata28
  );

  // Environment side: requester plus APB responder.
  modport slave (
    output req_valid28, req_write28, req_addr28, req_wdata28, prdata28, pready28,
    input  req_ready28, rsp_valid28, rsp_write28, rsp_rdata28, rsp_timeout28,
    input  psel28, penable28, pwrite28, paddr28, pwdata28
  );
endinterface

// File: rtl/apb_req_master28_fifo.sv
// Synchronous request FIFO with registered full/empty and extra-MSB wrap pointers.
module apb_req_master28_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 40
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [PW:0]      w_wr_nxt;
  logic [PW:0]      w_rd_nxt;

  assign w_push   = i_push & ~r_full;
  assign w_pop    = i_pop & ~r_empty;
  assign w_wr_nxt = r_wr_ptr + {{PW{1'b0}}, w_push};
  assign w_rd_nxt = r_rd_ptr + {{PW{1'b0}}, w_pop};

  // Pointers and flags; flags derive from next pointers so they are registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_full   <= (w_wr_nxt[PW] != w_rd_nxt[PW]) && (w_wr_nxt[PW-1:0] == w_rd_nxt[PW-1:0]);
      r_empty  <= (w_wr_nxt == w_rd_nxt);
    end
  end

  // Storage array; contents need no reset since the flags gate every read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr[PW-1:0]];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/apb_req_master28.sv
// APB initiator: buffers valid/ready requests and runs each as a SETUP/ACCESS transfer.
module apb_req_master28
  import apb_req_master28_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 pclk28,
  input  logic                 p_reset28,
  apb_req_master28_if.master   bus
);
  localparam int unsigned REQ_W = req_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned CW    = $clog2(TIMEOUT_CYCLES);

  logic [REQ_W-1:0]      w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_load;
  logic                  w_cnt_last;

  state_e                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_psel, w_psel_nxt;
  logic                  r_penable, w_penable_nxt;
  logic                  r_pwrite, w_pwrite_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic                  r_rsp_write, w_rsp_write_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_timeout, w_rsp_timeout_nxt;

  apb_req_master28_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .i_clk   (pclk28),
    .i_rst   (p_reset28),
    .i_push  (bus.req_valid28),
    .i_wdata ({bus.req_write28, bus.req_addr28, bus.req_wdata28}),
    .i_pop   (w_load),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_cnt_last = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Next-state and next-output decode; w_load pops the head into the APB registers.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_pwrite_nxt      = r_pwrite;
    w_paddr_nxt       = r_paddr;
    w_pwdata_nxt      = r_pwdata;
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_write_nxt   = r_rsp_write;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_load            = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_load        = ~w_empty;
      end
      StSetup: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = StAccess;
      end
      StAccess: begin
        if (bus.pready28 || w_cnt_last) begin
          // Completion or timeout abort; both report and move on the same way.
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_write_nxt   = r_pwrite;
          w_rsp_timeout_nxt = ~bus.pready28;
          w_rsp_rdata_nxt   = (bus.pready28 && !r_pwrite) ? bus.prdata28 : '0;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_state_nxt       = StIdle;
          w_load            = ~w_empty;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (w_load) begin
      w_pwrite_nxt  = w_head[REQ_W-1];
      w_paddr_nxt   = w_head[DATA_WIDTH +: ADDR_WIDTH];
      w_pwdata_nxt  = w_head[DATA_WIDTH-1:0];
      w_psel_nxt    = 1'b1;
      w_penable_nxt = 1'b0;
      w_state_nxt   = StSetup;
    end
  end

  // State, APB and response registers.
  always_ff @(posedge pclk28) begin
    if (p_reset28) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_write   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_paddr       <= w_paddr_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_write   <= w_rsp_write_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  assign bus.req_ready28   = ~w_full;
  assign bus.psel28        = r_psel;
  assign bus.penable28     = r_penable;
  assign bus.pwrite28      = r_pwrite;
  assign bus.paddr28       = r_paddr;
  assign bus.pwdata28      = r_pwdata;
  assign bus.rsp_valid28   = r_rsp_valid;
  assign bus.rsp_write28   = r_rsp_write;
  assign bus.rsp_rdata28   = r_rsp_rdata;
  assign bus.rsp_timeout28 = r_rsp_timeout;

endmodule

// File: tb/tb_apb_req_master28.sv
// Bench for the APB request master: transaction-level model plus directed literal checks.
module tb_apb_req_master28;
  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 16;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_req_master28_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_req_master28 #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk28    (clk),
    .p_reset28 (rst),
    .bus       (bus)
  );

  // Model: pending queue, current APB transfer, last response.
  req_t          mq[$];
  logic          m_ready = 1'b1;
  logic          m_sel = 1'b0, m_en = 1'b0, m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  int            m_wait = 0;
  logic          m_rv = 1'b0, m_rw = 1'b0, m_rt = 1'b0;
  logic [DW-1:0] m_rd = '0;
  logic          prev_rv = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic start_next();
    req_t r;
    r       = mq.pop_front();
    m_sel   = 1'b1;
    m_en    = 1'b0;
    m_wr    = r.w;
    m_addr  = r.a;
    m_wdata = r.d;
  endtask

  // Apply one clock edge's worth of specification rules to the model.
  task automatic model_edge();
    logic acc;
    req_t nr;
    acc = bus.req_valid28 && m_ready;
    nr  = '{w: bus.req_write28, a: bus.req_addr28, d: bus.req_wdata28};
    if (rst) begin
      mq.delete();
      m_ready = 1'b1;
      m_sel = 1'b0; m_en = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_wait = 0;
      m_rv = 1'b0; m_rw = 1'b0; m_rt = 1'b0; m_rd = '0;
      return;
    end
    m_rv = 1'b0;
    if (!m_sel) begin
      if (mq.size() > 0) start_next();
    end else if (!m_en) begin
      m_en   = 1'b1;
      m_wait = 0;
    end else if (bus.pready28 || m_wait == TO - 1) begin
      m_rv = 1'b1;
      m_rw = m_wr;
      m_rt = !bus.pready28;
      m_rd = (bus.pready28 && !m_wr) ? bus.prdata28 : '0;
      if (mq.size() > 0) start_next();
      else begin
        m_sel = 1'b0;
        m_en  = 1'b0;
      end
    end else begin
      m_wait++;
    end
    if (acc) mq.push_back(nr);
    m_ready = (mq.size() < DEPTH);
  endtask

  task automatic compare();
    chk("req_ready", 32'(bus.req_ready28), 32'(m_ready));
    chk("psel", 32'(bus.psel28), 32'(m_sel));
    chk("penable", 32'(bus.penable28), 32'(m_en));
    chk("pwrite", 32'(bus.pwrite28), 32'(m_wr));
    chk("paddr", 32'(bus.paddr28), 32'(m_addr));
    chk("pwdata", bus.pwdata28, m_wdata);
    chk("rsp_valid", 32'(bus.rsp_valid28), 32'(m_rv));
    chk("rsp_write", 32'(bus.rsp_write28), 32'(m_rw));
    chk("rsp_rdata", bus.rsp_rdata28, m_rd);
    chk("rsp_timeout", 32'(bus.rsp_timeout28), 32'(m_rt));
    chk("rsp_valid_pulse", 32'(prev_rv & bus.rsp_valid28), 32'(0));
    prev_rv = bus.rsp_valid28;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic set_req(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.req_valid28 = v;
    bus.req_write28 = w;
    bus.req_addr28  = a;
    bus.req_wdata28 = d;
  endtask

  initial begin
    int nr;
    int k;
    int stall;
    set_req(1'b0, 1'b0, '0, '0);
    bus.prdata28 = '0;
    bus.pready28 = 1'b1;
    rst = 1'b1;
    step();
    step();
    chk("reset_ready", 32'(bus.req_ready28), 32'(1));
    chk("reset_psel", 32'(bus.psel28), 32'(0));
    rst = 1'b0;
    step();

    // Single write, zero wait states.
    set_req(1'b1, 1'b1, 7'h05, 32'hA5A5_0001);
    step();
    set_req(1'b0, 1'b0, '0, '0);
    step();
    chk("wr_setup_psel", 32'(bus.psel28), 32'(1));
    chk("wr_setup_penable", 32'(bus.penable28), 32'(0));
    chk("wr_paddr", 32'(bus.paddr28), 32'h05);
    step();
    chk("wr_access_penable", 32'(bus.penable28), 32'(1));
    step();
    chk("wr_rsp_valid", 32'(bus.rsp_valid28), 32'(1));
    chk("wr_rsp_write", 32'(bus.rsp_write28), 32'(1));
    chk("wr_rsp_rdata", bus.rsp_rdata28, 32'h0);
    step();

    // Single read.
    bus.prdata28 = 32'h1234_5678;
    set_req(1'b1, 1'b0, 7'h10, 32'hFFFF_FFFF);
    step();
    set_req(1'b0, 1'b0, '0, '0);
    step();
    step();
    step();
    chk("rd_rsp_valid", 32'(bus.rsp_valid28), 32'(1));
    chk("rd_rsp_rdata", bus.rsp_rdata28, 32'h1234_5678);
    chk("rd_rsp_timeout", 32'(bus.rsp_timeout28), 32'(0));
    step();

    // Wait states: pready low for three ACCESS cycles.
    bus.pready28 = 1'b0;
    set_req(1'b1, 1'b1, 7'h22, 32'h0000_BEEF);
    step();
    set_req(1'b0, 1'b0, '0, '0);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ws_penable", 32'(bus.penable28), 32'(1));
      chk("ws_paddr", 32'(bus.paddr28), 32'h22);
      chk("ws_no_rsp", 32'(bus.rsp_valid28), 32'(0));
    end
    bus.pready28 = 1'b1;
    step();
    chk("ws_rsp_valid", 32'(bus.rsp_valid28), 32'(1));
    step();

    // Five requests back-to-back while the first transfer is stalled.
    bus.pready28 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, i[0], 7'(8'h40 + i), 32'hD000_0000 + i);
      bus.prdata28 = 32'h5500_0000 + i;
      step();
    end
    set_req(1'b0, 1'b0, '0, '0);
    chk("b2b_full_ready", 32'(bus.req_ready28), 32'(0));
    bus.pready28 = 1'b1;
    nr = 0;
    for (int i = 0; i < 30 && nr < 5; i++) begin
      bus.prdata28 = 32'h6600_0000 + i;
      step();
      if (bus.rsp_valid28) nr++;
      if (nr < 5) chk("b2b_psel", 32'(bus.psel28), 32'(1));
    end
    chk("b2b_rsp_count", 32'(nr), 32'(5));
    step();
    chk("b2b_idle_psel", 32'(bus.psel28), 32'(0));

    // Timeout abort, then the queued read proceeds.
    bus.pready28 = 1'b0;
    set_req(1'b1, 1'b1, 7'h31, 32'h1111_0000);
    step();
    set_req(1'b1, 1'b0, 7'h32, 32'h0);
    step();
    set_req(1'b0, 1'b0, '0, '0);
    k = 2;
    while (!bus.rsp_valid28 && k < 40) begin
      step();
      k++;
    end
    chk("to_latency", 32'(k), 32'(19));
    chk("to_flag", 32'(bus.rsp_timeout28), 32'(1));
    chk("to_rdata", bus.rsp_rdata28, 32'h0);
    bus.pready28 = 1'b1;
    bus.prdata28 = 32'hCAFE_0002;
    step();
    step();
    chk("to_next_valid", 32'(bus.rsp_valid28), 32'(1));
    chk("to_next_flag", 32'(bus.rsp_timeout28), 32'(0));
    chk("to_next_rdata", bus.rsp_rdata28, 32'hCAFE_0002);
    step();

    // Reset during ACCESS with two requests queued.
    bus.pready28 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b1, 7'(8'h50 + i), 32'h7000_0000 + i);
      step();
    end
    set_req(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_psel", 32'(bus.psel28), 32'(0));
    chk("rst_ready", 32'(bus.req_ready28), 32'(1));
    chk("rst_no_rsp", 32'(bus.rsp_valid28), 32'(0));
    bus.pready28 = 1'b1;
    step();
    step();
    chk("rst_flushed_psel", 32'(bus.psel28), 32'(0));

    // Randomized traffic with occasional long stalls and resets.
    stall = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom), $urandom);
      bus.prdata28 = $urandom;
      if (stall == 0 && $urandom_range(0, 99) == 0) stall = 20;
      if (stall > 0) begin
        bus.pready28 = 1'b0;
        stall--;
      end else begin
        bus.pready28 = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
